// File: rtl/crc5_seq_ctrl.sv
// Round-robin sequencer for the shared bit-serial CRC5 engine: grants, seeds, shifts bytes, returns CRC.
// Optional CRC_CHK_EN adds i_exp_crc/o_crc_err for an in-line check of RX-owned frames.
module crc5_seq_ctrl #(
  parameter int unsigned         DATA_W    = 8,
  parameter int unsigned         CRC_W     = 5,
  parameter logic [CRC_W-1:0]    CRC_SEED  = 5'h1F,
  parameter bit                  MSB_FIRST = 1'b0
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic [1:0]        i_req,
  input  logic [1:0]        i_byte_vld,
  input  logic [1:0]        i_byte_last,
  input  logic [DATA_W-1:0] i_byte_data0,
  input  logic [DATA_W-1:0] i_byte_data1,
  output logic [1:0]        o_byte_rdy,
  output logic [1:0]        o_gnt,
  output logic              o_eng_init,
  output logic [CRC_W-1:0]  o_eng_seed,
  output logic              o_eng_shift,
  output logic              o_eng_bit,
  input  logic [CRC_W-1:0]  i_eng_crc,
`ifdef CRC_CHK_EN
  input  logic [CRC_W-1:0]  i_exp_crc,
  output logic              o_crc_err,
`endif
  output logic              o_crc_done,
  output logic [CRC_W-1:0]  o_crc_value,
  output logic              o_crc_owner
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_INIT, S_LOAD, S_SHIFT, S_WAIT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q;
  logic                last_ptr_q;
  logic [DATA_W-1:0]   data_q;
  logic                byte_last_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CRC_W-1:0]    crc_value_q;
  logic                crc_owner_q;

  logic                win;
  logic                owner_req;
  logic                accept;
  logic                final_bit;
  logic [CNT_W-1:0]    bit_idx;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_last;

  // Tie goes to the requester that was not granted last.
  assign win       = (i_req == 2'b11) ? ~last_ptr_q : i_req[1];
  assign owner_req = i_req[owner_q];
  assign accept    = (state_q == S_LOAD) && owner_req && i_byte_vld[owner_q];
  assign final_bit = (cnt_q == CNT_W'(DATA_W - 1));
  assign bit_idx   = MSB_FIRST ? (CNT_W'(DATA_W - 1) - cnt_q) : cnt_q;
  assign sel_data  = owner_q ? i_byte_data1 : i_byte_data0;
  assign sel_last  = i_byte_last[owner_q];

  always_comb begin
    state_d     = state_q;
    o_byte_rdy  = 2'b00;
    o_gnt       = 2'b00;
    o_eng_init  = 1'b0;
    o_eng_shift = 1'b0;
    o_eng_bit   = 1'b0;
    o_crc_done  = 1'b0;
    if (state_q != S_IDLE) o_gnt = {owner_q, ~owner_q};
    case (state_q)
      S_IDLE: if (|i_req) state_d = S_ARB;
      S_ARB:  state_d = S_INIT;
      S_INIT: begin
        o_eng_init = 1'b1;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        if (owner_req) o_byte_rdy = {owner_q, ~owner_q};
        if (!owner_req)  state_d = S_IDLE;
        else if (accept) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        o_eng_shift = 1'b1;
        o_eng_bit   = data_q[bit_idx];
        if (!owner_req)     state_d = S_IDLE;
        else if (final_bit) state_d = byte_last_q ? S_WAIT : S_LOAD;
      end
      S_WAIT: state_d = owner_req ? S_DONE : S_IDLE;
      S_DONE: begin
        o_crc_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_ptr_q  <= 1'b1;
      data_q      <= '0;
      byte_last_q <= 1'b0;
      cnt_q       <= '0;
      crc_value_q <= '0;
      crc_owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && (|i_req)) owner_q <= win;
      if (state_q == S_ARB) last_ptr_q <= owner_q;
      if (accept) begin
        data_q      <= sel_data;
        byte_last_q <= sel_last;
        cnt_q       <= '0;
      end else if (state_q == S_SHIFT) begin
        cnt_q <= CNT_W'(cnt_q + 1'b1);
      end
      // Engine register is settled during WAIT; capture it so it is valid alongside done.
      if (state_q == S_WAIT && state_d == S_DONE) begin
        crc_value_q <= i_eng_crc;
        crc_owner_q <= owner_q;
      end
    end
  end

`ifdef CRC_CHK_EN
  logic crc_err_q;
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) crc_err_q <= 1'b0;
    else           crc_err_q <= (state_q == S_WAIT) && (state_d == S_DONE) && owner_q &&
                                (i_eng_crc != i_exp_crc);
  end
  assign o_crc_err = crc_err_q;
`endif

  assign o_eng_seed  = CRC_SEED;
  assign o_crc_value = crc_value_q;
  assign o_crc_owner = crc_owner_q;

endmodule

// File: tb/tb_crc5_seq_ctrl.sv
// Directed bench for crc5_seq_ctrl with a behavioural CRC5 engine (x^5+x^2+1, seed loaded on init).
// Define CRC_CHK_EN to also exercise the RX CRC check outputs.
module tb_crc5_seq_ctrl;

  logic       i_sys_clk;
  logic       i_sys_rst;
  logic [1:0] i_req;
  logic [1:0] i_byte_vld;
  logic [1:0] i_byte_last;
  logic [7:0] i_byte_data0;
  logic [7:0] i_byte_data1;
  logic [1:0] o_byte_rdy;
  logic [1:0] o_gnt;
  logic       o_eng_init;
  logic [4:0] o_eng_seed;
  logic       o_eng_shift;
  logic       o_eng_bit;
  logic [4:0] i_eng_crc;
  logic       o_crc_done;
  logic [4:0] o_crc_value;
  logic       o_crc_owner;
`ifdef CRC_CHK_EN
  logic [4:0] i_exp_crc;
  logic       o_crc_err;
`endif

  int n_chk = 0;
  int n_err = 0;
  int n_shift = 0, n_init = 0, n_rdy = 0, n_done = 0;
  int b_shift, b_init, b_rdy, b_done;
  bit ok;
  logic [7:0] pat;

  crc5_seq_ctrl dut (
    .i_sys_clk   (i_sys_clk),
    .i_sys_rst   (i_sys_rst),
    .i_req       (i_req),
    .i_byte_vld  (i_byte_vld),
    .i_byte_last (i_byte_last),
    .i_byte_data0(i_byte_data0),
    .i_byte_data1(i_byte_data1),
    .o_byte_rdy  (o_byte_rdy),
    .o_gnt       (o_gnt),
    .o_eng_init  (o_eng_init),
    .o_eng_seed  (o_eng_seed),
    .o_eng_shift (o_eng_shift),
    .o_eng_bit   (o_eng_bit),
    .i_eng_crc   (i_eng_crc),
`ifdef CRC_CHK_EN
    .i_exp_crc   (i_exp_crc),
    .o_crc_err   (o_crc_err),
`endif
    .o_crc_done  (o_crc_done),
    .o_crc_value (o_crc_value),
    .o_crc_owner (o_crc_owner)
  );

  initial i_sys_clk = 1'b0;
  always #5 i_sys_clk = ~i_sys_clk;

  // Serial CRC5 engine model.
  always @(posedge i_sys_clk) begin
    if (o_eng_init)       i_eng_crc <= o_eng_seed;
    else if (o_eng_shift) i_eng_crc <= {i_eng_crc[3:0], 1'b0} ^ ((i_eng_crc[4] ^ o_eng_bit) ? 5'h05 : 5'h00);
  end

  always @(negedge i_sys_clk) begin
    if (o_eng_shift)  n_shift++;
    if (o_eng_init)   n_init++;
    if (|o_byte_rdy)  n_rdy++;
    if (o_crc_done)   n_done++;
  end

  task automatic step();
    @(posedge i_sys_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int max, output bit found);
    found = 1'b0;
    for (int k = 0; k < max; k++) begin
      step();
      if (o_crc_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    i_sys_rst = 1'b1; i_req = 2'b00; i_byte_vld = 2'b00; i_byte_last = 2'b00;
    i_byte_data0 = 8'h00; i_byte_data1 = 8'h00; i_eng_crc = 5'h00;
`ifdef CRC_CHK_EN
    i_exp_crc = 5'h00;
`endif
    step(); step();
    chk("rst_gnt",   o_gnt, 2'b00);
    chk("rst_rdy",   o_byte_rdy, 2'b00);
    chk("rst_init",  o_eng_init, 1'b0);
    chk("rst_shift", o_eng_shift, 1'b0);
    chk("rst_done",  o_crc_done, 1'b0);
    chk("rst_value", o_crc_value, 5'h00);
    chk("rst_owner", o_crc_owner, 1'b0);
    chk("rst_seed",  o_eng_seed, 5'h1F);
    i_sys_rst = 1'b0;
    step();

    // 3-byte TX frame, valid always high.
    b_shift = n_shift; b_init = n_init; b_rdy = n_rdy; b_done = n_done;
    i_req = 2'b01; i_byte_vld = 2'b01; i_byte_last = 2'b00; i_byte_data0 = 8'h3C;
    for (int c = 1; c <= 31; c++) begin
      step();
      if (c == 1) chk("t3_gnt", o_gnt, 2'b01);
      if (c == 2) chk("t3_init", o_eng_init, 1'b1);
      if (c == 3 || c == 12 || c == 21) chk("t3_rdy", o_byte_rdy, 2'b01);
      if (c == 13) i_byte_last = 2'b01;
      if (c == 31) chk("t3_done", o_crc_done, 1'b1);
    end
    i_req = 2'b00; i_byte_vld = 2'b00; i_byte_last = 2'b00;
    step();
    chk("t3_nshift", n_shift - b_shift, 24);
    chk("t3_ninit",  n_init - b_init, 1);
    chk("t3_nrdy",   n_rdy - b_rdy, 3);
    chk("t3_ndone",  n_done - b_done, 1);

    // Single byte 0xA5, LSB first, expected CRC 5'h01.
    pat = 8'hA5;
    i_req = 2'b01; i_byte_vld = 2'b01; i_byte_last = 2'b01; i_byte_data0 = 8'hA5;
    step(); chk("t1_gnt", o_gnt, 2'b01); chk("t1_arb_init", o_eng_init, 1'b0);
    step(); chk("t1_init", o_eng_init, 1'b1);
    step(); chk("t1_rdy", o_byte_rdy, 2'b01);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1_shift", o_eng_shift, 1'b1);
      chk("t1_bit", o_eng_bit, pat[i]);
    end
    step(); chk("t1_wait_shift", o_eng_shift, 1'b0); chk("t1_wait_done", o_crc_done, 1'b0);
    step();
    chk("t1_done", o_crc_done, 1'b1);
    chk("t1_value", o_crc_value, 5'h01);
    chk("t1_owner", o_crc_owner, 1'b0);
    chk("t1_done_gnt", o_gnt, 2'b01);
    i_req = 2'b00; i_byte_vld = 2'b00; i_byte_last = 2'b00;
    step(); chk("t1_idle_gnt", o_gnt, 2'b00); chk("t1_idle_done", o_crc_done, 1'b0);

    // Abort during shift of byte 2.
    b_done = n_done;
    i_req = 2'b01; i_byte_vld = 2'b01; i_byte_last = 2'b00; i_byte_data0 = 8'h5A;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 12) chk("t4_rdy2", o_byte_rdy, 2'b01);
      if (c == 15) begin
        chk("t4_shift", o_eng_shift, 1'b1);
        i_req = 2'b00;
      end
    end
    chk("t4_gnt", o_gnt, 2'b00);
    chk("t4_noshift", o_eng_shift, 1'b0);
    i_byte_vld = 2'b00;
    repeat (12) step();
    chk("t4_nodone", n_done - b_done, 0);
    chk("t4_value", o_crc_value, 5'h01);

    // Reset while shifting.
    i_req = 2'b01; i_byte_vld = 2'b01; i_byte_last = 2'b01; i_byte_data0 = 8'hFF;
    repeat (6) step();
    chk("t5_shift", o_eng_shift, 1'b1);
    i_sys_rst = 1'b1;
    #1;
    chk("t5_rst_shift", o_eng_shift, 1'b0);
    chk("t5_rst_bit",   o_eng_bit, 1'b0);
    chk("t5_rst_gnt",   o_gnt, 2'b00);
    chk("t5_rst_value", o_crc_value, 5'h00);
    step();
    i_sys_rst = 1'b0;
    step(); chk("t5_gnt", o_gnt, 2'b01);
    step(); chk("t5_init", o_eng_init, 1'b1);
    i_req = 2'b00; i_byte_vld = 2'b00;
    repeat (3) step();

    // Round-robin from reset with both requesting.
    i_sys_rst = 1'b1;
    step();
    i_sys_rst = 1'b0;
    i_req = 2'b11; i_byte_vld = 2'b11; i_byte_last = 2'b11; i_byte_data0 = 8'hA5; i_byte_data1 = 8'hA5;
    step(); chk("t2_gnt0", o_gnt, 2'b01);
    step();
    step(); chk("t2_rdy_owner_only", o_byte_rdy, 2'b01);
    wait_done(20, ok);
    chk("t2_done0", ok, 1'b1);
    chk("t2_owner0", o_crc_owner, 1'b0);
    chk("t2_value0", o_crc_value, 5'h01);
    step(); chk("t2_idle", o_gnt, 2'b00);
    step(); chk("t2_gnt1", o_gnt, 2'b10);
    wait_done(25, ok);
    chk("t2_done1", ok, 1'b1);
    chk("t2_owner1", o_crc_owner, 1'b1);
    chk("t2_value1", o_crc_value, 5'h01);
    step();
    step(); chk("t2_gnt_again", o_gnt, 2'b01);
    i_req = 2'b00; i_byte_vld = 2'b00; i_byte_last = 2'b00;
    repeat (5) step();

`ifdef CRC_CHK_EN
    i_req = 2'b10; i_byte_vld = 2'b10; i_byte_last = 2'b10; i_byte_data1 = 8'hA5; i_exp_crc = 5'h01;
    wait_done(30, ok);
    chk("chk_done_ok", ok, 1'b1);
    chk("chk_err0", o_crc_err, 1'b0);
    i_req = 2'b00;
    step(); step();
    i_exp_crc = 5'h01 ^ 5'h01;
    i_req = 2'b10;
    wait_done(30, ok);
    chk("chk_done_bad", ok, 1'b1);
    chk("chk_err1", o_crc_err, 1'b1);
    i_req = 2'b00; i_byte_vld = 2'b00;
    step(); chk("chk_err_pulse", o_crc_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
